memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 141 ++++++++++++++
 tb/tb_memory_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-port memory arbiter: instruction fetch vs. data port (load/store) onto one downstream
// request/ack channel, at most one transaction outstanding, round-robin on contention.

module memory_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned BYTES_WIDTH = $clog2(DATA_WIDTH / 8) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,

    // Instruction fetch port
    input  logic [ADDR_WIDTH-1:0]  if_addr,
    input  logic                   if_activate,
    output logic [DATA_WIDTH-1:0]  if_data,
    output logic                   if_done,

    // Data port, load side
    input  logic [ADDR_WIDTH-1:0]  dm_fetch_addr,
    input  logic                   dm_fetch_activate,
    output logic [DATA_WIDTH-1:0]  dm_fetched_data,
    output logic                   dm_fetch_done,

    // Data port, store side
    input  logic [ADDR_WIDTH-1:0]  dm_write_addr,
    input  logic [DATA_WIDTH-1:0]  dm_write_data,
    input  logic [BYTES_WIDTH-1:0] dm_bytes_to_write,
    input  logic                   dm_write_activate,
    output logic                   dm_write_done,

    // Downstream memory
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   mem_we,
    output logic [BYTES_WIDTH-1:0] mem_bytes,
    output logic                   mem_req,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_ack
);

    localparam logic [BYTES_WIDTH-1:0] WordBytes = BYTES_WIDTH'(DATA_WIDTH / 8);

    // The busy state doubles as the registered requester id.
    typedef enum logic [2:0] {
        StIdle,
        StBusyIf,
        StBusyLd,
        StBusySt,
        StDone
    } state_e;

    state_e                  state_q;
    logic                    last_dm_q;   // 0: fetch granted last, 1: data port granted last
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic dm_any;
    logic pick_dm;
    logic pick_if;

    // A tie goes to whichever port was not served last.
    always_comb begin
        dm_any  = dm_write_activate | dm_fetch_activate;
        pick_dm = dm_any && (!if_activate || !last_dm_q);
        pick_if = if_activate && !pick_dm;
    end

    assign if_data         = rdata_q;
    assign dm_fetched_data = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            last_dm_q     <= 1'b0;
            rdata_q       <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_bytes     <= '0;
            if_done       <= 1'b0;
            dm_fetch_done <= 1'b0;
            dm_write_done <= 1'b0;
        end else begin
            if_done       <= 1'b0;
            dm_fetch_done <= 1'b0;
            dm_write_done <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (pick_dm) begin
                        mem_req   <= 1'b1;
                        last_dm_q <= 1'b1;
                        if (dm_write_activate) begin
                            mem_addr  <= dm_write_addr;
                            mem_wdata <= dm_write_data;
                            mem_we    <= 1'b1;
                            mem_bytes <= dm_bytes_to_write;
                            state_q   <= StBusySt;
                        end else begin
                            mem_addr  <= dm_fetch_addr;
                            mem_wdata <= '0;
                            mem_we    <= 1'b0;
                            mem_bytes <= WordBytes;
                            state_q   <= StBusyLd;
                        end
                    end else if (pick_if) begin
                        mem_req   <= 1'b1;
                        last_dm_q <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_we    <= 1'b0;
                        mem_bytes <= WordBytes;
                        state_q   <= StBusyIf;
                    end
                end

                StBusyIf, StBusyLd, StBusySt: begin
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        mem_req <= 1'b0;
                        state_q <= StDone;
                        // A requester that has withdrawn gets no completion pulse.
                        if_done       <= (state_q == StBusyIf) && if_activate;
                        dm_fetch_done <= (state_q == StBusyLd) && dm_fetch_activate;
                        dm_write_done <= (state_q == StBusySt) && dm_write_activate;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table plus hand-written
// sequences for tie-breaking, withdrawal, store/load ordering and reset mid-transaction.

module tb_memory_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] if_addr;
    logic          if_activate;
    logic [DW-1:0] if_data;
    logic          if_done;
    logic [AW-1:0] dm_fetch_addr;
    logic          dm_fetch_activate;
    logic [DW-1:0] dm_fetched_data;
    logic          dm_fetch_done;
    logic [AW-1:0] dm_write_addr;
    logic [DW-1:0] dm_write_data;
    logic [BW-1:0] dm_bytes_to_write;
    logic          dm_write_activate;
    logic          dm_write_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [BW-1:0] mem_bytes;
    logic          mem_req;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    int n_checks = 0;
    int n_errors = 0;

    memory_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .if_addr           (if_addr),
        .if_activate       (if_activate),
        .if_data           (if_data),
        .if_done           (if_done),
        .dm_fetch_addr     (dm_fetch_addr),
        .dm_fetch_activate (dm_fetch_activate),
        .dm_fetched_data   (dm_fetched_data),
        .dm_fetch_done     (dm_fetch_done),
        .dm_write_addr     (dm_write_addr),
        .dm_write_data     (dm_write_data),
        .dm_bytes_to_write (dm_bytes_to_write),
        .dm_write_activate (dm_write_activate),
        .dm_write_done     (dm_write_done),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_we            (mem_we),
        .mem_bytes         (mem_bytes),
        .mem_req           (mem_req),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack)
    );

    always #5 clk = ~clk;

    // port: 0 fetch, 1 load, 2 store, 3 store+load together
    // exp_done one-hot: bit0 if_done, bit1 dm_fetch_done, bit2 dm_write_done
    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] bytes;
        logic [DW-1:0] rdata;
        int            ack_delay;
        logic          exp_we;
        logic [BW-1:0] exp_bytes;
        logic [2:0]    exp_done;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drop_all();
        if_activate       = 1'b0;
        dm_fetch_activate = 1'b0;
        dm_write_activate = 1'b0;
    endtask

    // Bounded wait for mem_req; an expired bound shows up as a failed check.
    task automatic wait_req(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) break;
        end
        check({name, " mem_req"}, mem_req, 1);
    endtask

    task automatic ack_now(input logic [DW-1:0] rd);
        mem_rdata = rd;
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t  v;
        string nm;
        v  = vecs[idx];
        nm = $sformatf("vec%0d", idx);
        case (v.port)
            0: begin if_addr = v.addr; if_activate = 1'b1; end
            1: begin dm_fetch_addr = v.addr; dm_fetch_activate = 1'b1; end
            default: begin
                dm_write_addr     = v.addr;
                dm_write_data     = v.data;
                dm_bytes_to_write = v.bytes;
                dm_write_activate = 1'b1;
                if (v.port == 3) begin
                    dm_fetch_addr     = 32'hDEAD_0000;
                    dm_fetch_activate = 1'b1;
                end
            end
        endcase
        wait_req(nm);
        check({nm, " mem_we"}, mem_we, v.exp_we);
        check({nm, " mem_addr"}, mem_addr, v.addr);
        check({nm, " mem_bytes"}, mem_bytes, v.exp_bytes);
        if (v.exp_we) check({nm, " mem_wdata"}, mem_wdata, v.data);
        for (int i = 0; i < v.ack_delay; i++) begin
            @(negedge clk);
            check({nm, " hold mem_req"}, mem_req, 1);
            check({nm, " hold mem_addr"}, mem_addr, v.addr);
        end
        ack_now(v.rdata);
        check({nm, " if_done"}, if_done, v.exp_done[0]);
        check({nm, " dm_fetch_done"}, dm_fetch_done, v.exp_done[1]);
        check({nm, " dm_write_done"}, dm_write_done, v.exp_done[2]);
        check({nm, " mem_req dropped"}, mem_req, 0);
        if (v.exp_done[0]) check({nm, " if_data"}, if_data, v.rdata);
        if (v.exp_done[1]) check({nm, " dm_fetched_data"}, dm_fetched_data, v.rdata);
        drop_all();
        @(negedge clk);
        check({nm, " dones after"}, {if_done, dm_fetch_done, dm_write_done}, 0);
    endtask

    logic          exp_ld;
    logic [DW-1:0] rd;

    initial begin
        vecs[0] = '{0, 32'h0000_0100, 32'h0,          3'd0, 32'h0000_0013, 0, 1'b0, 3'd4, 3'b001};
        vecs[1] = '{2, 32'h0000_2000, 32'h0000_00AB, 3'd1, 32'h0,          0, 1'b1, 3'd1, 3'b100};
        vecs[2] = '{1, 32'h0000_3004, 32'h0,          3'd0, 32'hCAFE_BABE, 2, 1'b0, 3'd4, 3'b010};
        vecs[3] = '{2, 32'h0000_4002, 32'h0000_BEEF, 3'd2, 32'h0,          1, 1'b1, 3'd2, 3'b100};
        vecs[4] = '{2, 32'h0000_5000, 32'h1234_5678, 3'd4, 32'h0,          0, 1'b1, 3'd4, 3'b100};
        vecs[5] = '{2, 32'h0000_6000, 32'h0000_0055, 3'd3, 32'h0,          0, 1'b1, 3'd3, 3'b100};
        vecs[6] = '{3, 32'h0000_7000, 32'h0000_0009, 3'd1, 32'h0,          0, 1'b1, 3'd1, 3'b100};
        vecs[7] = '{0, 32'h0000_0008, 32'h0,          3'd0, 32'hFFFF_0000, 4, 1'b0, 3'd4, 3'b001};

        rst_n = 1'b0;
        drop_all();
        if_addr = '0; dm_fetch_addr = '0; dm_write_addr = '0;
        dm_write_data = '0; dm_bytes_to_write = '0;
        mem_rdata = '0; mem_ack = 1'b0;

        // Both fetch and load requesting from reset onwards.
        if_addr = 32'h0000_1000; if_activate = 1'b1;
        dm_fetch_addr = 32'h0000_2000; dm_fetch_activate = 1'b1;
        repeat (2) @(negedge clk);
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst mem_bytes", mem_bytes, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst dones", {if_done, dm_fetch_done, dm_write_done}, 0);
        check("rst rdata", if_data, 0);

        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_ld = (k % 2 == 0);
            rd     = 32'h1111_0000 + k;
            if (k > 0) begin
                @(negedge clk);
                check($sformatf("tie%0d idle gap", k), mem_req, 0);
            end
            @(negedge clk);
            check($sformatf("tie%0d mem_req", k), mem_req, 1);
            check($sformatf("tie%0d mem_addr", k), mem_addr,
                  exp_ld ? 32'h0000_2000 : 32'h0000_1000);
            ack_now(rd);
            check($sformatf("tie%0d dm_fetch_done", k), dm_fetch_done, exp_ld);
            check($sformatf("tie%0d if_done", k), if_done, !exp_ld);
            check($sformatf("tie%0d dm_write_done", k), dm_write_done, 0);
            check($sformatf("tie%0d data", k), exp_ld ? dm_fetched_data : if_data, rd);
        end
        drop_all();
        @(negedge clk);
        check("tie end dones", {if_done, dm_fetch_done, dm_write_done}, 0);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Fetch withdrawn while the downstream ack is late.
        if_addr = 32'h0000_0044; if_activate = 1'b1;
        wait_req("wd");
        if_activate = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("wd hold mem_req", mem_req, 1);
        end
        ack_now(32'h0000_0077);
        check("wd no if_done", if_done, 0);
        check("wd mem_req dropped", mem_req, 0);
        @(negedge clk);
        check("wd no if_done later", if_done, 0);

        // Store and load together: store first, then the load.
        dm_write_addr = 32'h0000_9000; dm_write_data = 32'h0000_1234;
        dm_bytes_to_write = 3'd2; dm_write_activate = 1'b1;
        dm_fetch_addr = 32'h0000_A000; dm_fetch_activate = 1'b1;
        wait_req("sl st");
        check("sl st mem_we", mem_we, 1);
        check("sl st mem_addr", mem_addr, 32'h0000_9000);
        ack_now(32'h0);
        check("sl st done", dm_write_done, 1);
        check("sl st no ld done", dm_fetch_done, 0);
        dm_write_activate = 1'b0;
        @(negedge clk);
        check("sl gap", mem_req, 0);
        @(negedge clk);
        check("sl ld mem_req", mem_req, 1);
        check("sl ld mem_we", mem_we, 0);
        check("sl ld mem_addr", mem_addr, 32'h0000_A000);
        check("sl ld mem_bytes", mem_bytes, 4);
        ack_now(32'h0000_5A5A);
        check("sl ld done", dm_fetch_done, 1);
        check("sl ld data", dm_fetched_data, 32'h0000_5A5A);
        check("sl ld no st done", dm_write_done, 0);
        drop_all();
        @(negedge clk);

        // Reset while a store is outstanding.
        dm_write_addr = 32'h0000_B000; dm_write_data = 32'h0000_00EE;
        dm_bytes_to_write = 3'd1; dm_write_activate = 1'b1;
        wait_req("rm");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rm async mem_req", mem_req, 0);
        check("rm async mem_we", mem_we, 0);
        dm_write_activate = 1'b0;
        if_addr = 32'h0000_0C00; if_activate = 1'b1;
        dm_fetch_addr = 32'h0000_0D00; dm_fetch_activate = 1'b1;
        @(negedge clk);
        check("rm no st done", dm_write_done, 0);
        rst_n   = 1'b1;
        mem_ack = 1'b1;  // stale ack from the abandoned store
        @(negedge clk);
        mem_ack = 1'b0;
        check("rm post grant mem_req", mem_req, 1);
        check("rm post grant data port", mem_addr, 32'h0000_0D00);
        check("rm post dones", {if_done, dm_fetch_done, dm_write_done}, 0);
        @(negedge clk);
        check("rm stale ack ignored", mem_req, 1);
        ack_now(32'h0000_0042);
        check("rm ld done", dm_fetch_done, 1);
        check("rm ld data", dm_fetched_data, 32'h0000_0042);
        check("rm no if_done", if_done, 0);
        drop_all();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
